// File: rtl/abs_boxcar_decimator.sv
// abs_boxcar_decimator: windowed sum/mean/peak of an unsigned magnitude stream, one strobe per 2**LOG2_N samples
module abs_boxcar_decimator #(
   parameter int DW     = 16,
   parameter int LOG2_N = 10
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic                 clear_i,
   input  logic [DW-1:0]        abs_data_i,
   output logic [DW+LOG2_N-1:0] sum_o,
   output logic [DW-1:0]        mean_o,
   output logic [DW-1:0]        peak_o,
   output logic                 valid_o,
   output logic [LOG2_N-1:0]    count_o
);
   localparam int AW = DW + LOG2_N;
   logic [AW-1:0]     acc_q, acc_d, sum_q, sum_d, in_sum;
   logic [DW-1:0]     peak_acc_q, peak_acc_d, peak_q, peak_d, mean_q, mean_d, in_peak;
   logic [LOG2_N-1:0] count_q, count_d;
   logic              valid_q, valid_d, take, close;
   // Accumulate accepted samples; the window closes when the all-ones count accepts one more
   always_comb begin
      in_sum     = acc_q + {{LOG2_N{1'b0}}, abs_data_i};
      in_peak    = (abs_data_i > peak_acc_q) ? abs_data_i : peak_acc_q;
      take       = en_i & ~clear_i;
      close      = take & (&count_q);
      acc_d      = (clear_i | close) ? '0 : take ? in_sum : acc_q;
      peak_acc_d = (clear_i | close) ? '0 : take ? in_peak : peak_acc_q;
      count_d    = clear_i ? '0 : take ? count_q + 1'b1 : count_q;
      sum_d      = close ? in_sum : sum_q;
      mean_d     = close ? in_sum[AW-1:LOG2_N] : mean_q;
      peak_d     = close ? in_peak : peak_q;
      valid_d    = close;
   end
   // State and result registers; reset dominates clear and enable
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q      <= '0;
         peak_acc_q <= '0;
         count_q    <= '0;
         sum_q      <= '0;
         mean_q     <= '0;
         peak_q     <= '0;
         valid_q    <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         peak_acc_q <= peak_acc_d;
         count_q    <= count_d;
         sum_q      <= sum_d;
         mean_q     <= mean_d;
         peak_q     <= peak_d;
         valid_q    <= valid_d;
      end
   end
   assign sum_o   = sum_q;
   assign mean_o  = mean_q;
   assign peak_o  = peak_q;
   assign valid_o = valid_q;
   assign count_o = count_q;
endmodule
